// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 matrix keypad scanner with debounce and valid/ready key output
module keypad_scan_ctrl #(
    parameter int unsigned DELAY  = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       g_reset,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready
);

    localparam logic [18:0] DELAY_C  = 19'(DELAY);
    localparam logic [7:0]  SETTLE_C = 8'(SETTLE);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESENT  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t      r_state;
    logic [1:0]  r_row_idx;
    logic [7:0]  r_settle_cnt;
    logic [18:0] r_stable_cnt;
    logic [3:0]  r_sample;
    logic [3:0]  r_row;
    logic [3:0]  r_key_code;
    logic        r_key_valid;

    logic [1:0]  w_row_next;
    logic [1:0]  w_col_idx;
    logic        w_col_idle;
    logic        w_settled;
    logic        w_stable_done;

    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << idx;
        return ~one_hot;
    endfunction

    assign w_row_next    = r_row_idx + 2'd1;
    assign w_col_idle    = (col == 4'hF);
    assign w_settled     = (r_settle_cnt == SETTLE_C);
    assign w_stable_done = (r_stable_cnt == DELAY_C);

    // Lowest-index pressed column wins when several keys share the row.
    always_comb begin
        w_col_idx = 2'd3;
        if (!r_sample[0])      w_col_idx = 2'd0;
        else if (!r_sample[1]) w_col_idx = 2'd1;
        else if (!r_sample[2]) w_col_idx = 2'd2;
    end

    always_ff @(posedge clk) begin
        if (g_reset) begin
            r_state      <= SCAN;
            r_row_idx    <= 2'd0;
            r_settle_cnt <= 8'd0;
            r_stable_cnt <= 19'd0;
            r_sample     <= 4'hF;
            r_row        <= 4'b1110;
            r_key_code   <= 4'h0;
            r_key_valid  <= 1'b0;
        end else begin
            case (r_state)
                SCAN: begin
                    if (!w_settled) begin
                        r_settle_cnt <= r_settle_cnt + 8'd1;
                    end else if (w_col_idle) begin
                        r_row_idx    <= w_row_next;
                        r_row        <= row_drive(w_row_next);
                        r_settle_cnt <= 8'd0;
                    end else begin
                        r_sample     <= col;
                        r_stable_cnt <= 19'd0;
                        r_state      <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (col != r_sample) begin
                        r_settle_cnt <= 8'd0;
                        r_state      <= SCAN;
                    end else if (w_stable_done) begin
                        r_key_code  <= {r_row_idx, w_col_idx};
                        r_key_valid <= 1'b1;
                        r_state     <= PRESENT;
                    end else begin
                        r_stable_cnt <= r_stable_cnt + 19'd1;
                    end
                end
                PRESENT: begin
                    // Columns are ignored here so a held or bouncing key yields one transfer.
                    if (key_ready) begin
                        r_key_valid  <= 1'b0;
                        r_stable_cnt <= 19'd0;
                        r_state      <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!w_col_idle) begin
                        r_stable_cnt <= 19'd0;
                    end else if (w_stable_done) begin
                        r_row_idx    <= w_row_next;
                        r_row        <= row_drive(w_row_next);
                        r_settle_cnt <= 8'd0;
                        r_state      <= SCAN;
                    end else begin
                        r_stable_cnt <= r_stable_cnt + 19'd1;
                    end
                end
                default: begin
                    r_state <= SCAN;
                end
            endcase
        end
    end

    assign row       = r_row;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - scoreboard bench for keypad_scan_ctrl
module tb_keypad_scan_ctrl;

    logic       clk = 1'b0;
    logic       g_reset = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready = 1'b0;

    logic       key_down = 1'b0;
    logic [1:0] key_row  = 2'd0;
    logic [3:0] key_pat  = 4'hF;

    int tests_run    = 0;
    int tests_failed = 0;
    int xfers        = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    // Keypad model: the held key only pulls its columns low while its row is driven.
    assign col = (key_down && (row[key_row] == 1'b0)) ? key_pat : 4'hF;

    keypad_scan_ctrl #(.DELAY(2), .SETTLE(1)) u_dut (
        .clk       (clk),
        .g_reset   (g_reset),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        g_reset  = 1'b1;
        key_down = 1'b0;
        tick();
        tick();
        g_reset  = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles, output int n);
        n = 0;
        while (!key_valid && n < max_cycles) begin
            tick();
            n++;
        end
        if (!key_valid) check("wait_valid_timeout", 0, 1);
    endtask

    // Monitor: a transfer completes on the next edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (!g_reset && key_valid && key_ready) begin
            xfers++;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_transfer: got key_code %0h expected no transfer", key_code);
            end else begin
                logic [3:0] exp_code;
                exp_code = exp_q.pop_front();
                if (key_code != exp_code) begin
                    tests_failed++;
                    $display("FAIL transfer_code: got %0h expected %0h", key_code, exp_code);
                end
            end
        end
    end

    initial begin
        int n;
        int bounce_err;
        int xfers_before;

        // Reset state and idle row rotation
        do_reset();
        check("reset_row", row, 4'b1110);
        check("reset_valid", key_valid, 0);
        check("reset_code", key_code, 0);
        for (int k = 0; k < 9; k++) begin
            logic [3:0] exp_row;
            exp_row = ~(4'b0001 << ((k / 2) % 4));
            check("idle_row", row, exp_row);
            check("idle_valid", key_valid, 0);
            tick();
        end

        // Row 2 col 1, ready held high
        do_reset();
        key_ready = 1'b1;
        key_row   = 2'd2;
        key_pat   = 4'b1101;
        key_down  = 1'b1;
        exp_q.push_back(4'h9);
        n = 0;
        while (row != 4'b1011 && n < 20) begin
            tick();
            n++;
        end
        check("reach_row2", row, 4'b1011);
        wait_valid(20, n);
        check("latency_row2", n, 5);
        check("code_row2", key_code, 4'h9);
        key_down = 1'b0;
        tick();
        check("valid_one_cycle", key_valid, 0);
        check("code_retained", key_code, 4'h9);
        for (int k = 0; k < 10; k++) tick();

        // Bounce on row 0
        do_reset();
        key_ready  = 1'b1;
        key_row    = 2'd0;
        key_pat    = 4'b1101;
        bounce_err = 0;
        for (int k = 0; k < 24; k++) begin
            key_down = ~key_down;
            tick();
            if (key_valid) bounce_err++;
        end
        check("bounce_no_valid", bounce_err, 0);
        key_down = 1'b1;
        exp_q.push_back(4'h1);
        wait_valid(40, n);
        check("bounce_code", key_code, 4'h1);
        tick();
        key_down = 1'b0;
        for (int k = 0; k < 10; k++) tick();

        // Backpressure with release during PRESENT
        do_reset();
        key_ready = 1'b0;
        key_row   = 2'd1;
        key_pat   = 4'b0111;
        key_down  = 1'b1;
        exp_q.push_back(4'h7);
        wait_valid(40, n);
        key_down = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_valid_hold", key_valid, 1);
            check("bp_code_hold", key_code, 4'h7);
        end
        key_ready = 1'b1;
        tick();
        check("bp_valid_fall", key_valid, 0);
        check("bp_row_release0", row, 4'b1101);
        tick();
        tick();
        check("bp_row_release2", row, 4'b1101);
        tick();
        check("bp_row_resume", row, 4'b1011);

        // Multi-key on row 3, held indefinitely
        do_reset();
        key_ready    = 1'b1;
        key_row      = 2'd3;
        key_pat      = 4'b0101;
        key_down     = 1'b1;
        xfers_before = xfers;
        exp_q.push_back(4'hD);
        wait_valid(60, n);
        check("multi_code", key_code, 4'hD);
        for (int k = 0; k < 80; k++) tick();
        check("multi_one_xfer", xfers - xfers_before, 1);

        // Reset pulse during PRESENT discards the key
        key_down = 1'b0;
        do_reset();
        key_ready = 1'b0;
        key_row   = 2'd2;
        key_pat   = 4'b1011;
        key_down  = 1'b1;
        wait_valid(40, n);
        check("pre_reset_code", key_code, 4'hA);
        g_reset  = 1'b1;
        key_down = 1'b0;
        tick();
        g_reset  = 1'b0;
        check("rst_valid", key_valid, 0);
        check("rst_row", row, 4'b1110);
        check("rst_code", key_code, 0);
        key_ready    = 1'b1;
        xfers_before = xfers;
        for (int k = 0; k < 20; k++) tick();
        check("rst_no_xfer", xfers - xfers_before, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameter DELAY, default 2: number of consecutive stable cycles required to accept a key press or release; legal range 0..524287.
REQ-002 SHALL have parameter SETTLE, default 1: number of idle cycles after a row drive change before the columns are sampled; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state changes on posedge clk.
REQ-004 SHALL have port g_reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port row, output, 4 bits: active-low one-hot row drive; exactly one bit is low at all times.
REQ-006 SHALL have port col, input, 4 bits: active-low column sense, already synchronised to clk; 4'hF means no key pressed.
REQ-007 SHALL have port key_code, output, 4 bits: {row_idx[1:0], col_idx[1:0]} of the accepted key.
REQ-008 SHALL have port key_valid, output, 1 bit: high while key_code holds an unconsumed key.
REQ-009 SHALL have port key_ready, input, 1 bit: consumer accepts the key; a transfer occurs on a clock edge where key_valid and key_ready are both high.

Function
REQ-010 SHALL implement the FSM states SCAN, DEBOUNCE, PRESENT and RELEASE, plus a 2-bit row_idx, an 8-bit settle counter and a 19-bit stable counter.
REQ-011 SCAN SHALL drive row = ~(4'b0001 << row_idx) and count SETTLE cycles; on the following cycle it SHALL sample col.
REQ-012 In SCAN, if the sample is 4'hF, the block SHALL increment row_idx (3 wraps to 0), restart the settle count and remain in SCAN.
REQ-013 In SCAN, if the sample is not 4'hF, the block SHALL capture the sample, clear the stable counter and enter DEBOUNCE without changing row_idx.
REQ-014 In DEBOUNCE, the block SHALL compare col against the captured sample every cycle; on any mismatch it SHALL return to SCAN on the same row with the settle count restarted.
REQ-015 In DEBOUNCE, on a match with stable counter == DELAY, the block SHALL load key_code and enter PRESENT; otherwise it SHALL increment the stable counter. DEBOUNCE therefore occupies DELAY+1 cycles.
REQ-016 col_idx SHALL be the lowest index of a zero bit in the captured sample; multiple zeros are resolved as lowest index wins.
REQ-017 key_valid SHALL be high exactly while in PRESENT, and key_code SHALL remain stable throughout PRESENT.
REQ-018 In PRESENT, on key_valid && key_ready the block SHALL enter RELEASE with the stable counter cleared; key_valid SHALL fall on that same edge.
REQ-019 If key_ready is already high when PRESENT is entered, the transfer SHALL complete after exactly one cycle of key_valid.
REQ-020 In RELEASE, row SHALL remain unchanged; col == 4'hF for DELAY+1 consecutive cycles SHALL increment row_idx and enter SCAN; any col != 4'hF SHALL clear the stable counter.
REQ-021 Column activity in PRESENT (release or bounce) SHALL NOT affect key_valid or key_code; one press SHALL yield exactly one transfer.
REQ-022 key_code SHALL retain its last value outside PRESENT.

Reset
REQ-023 While g_reset is high at a clock edge, the block SHALL set: state SCAN, row_idx 0, row 4'b1110, key_valid 0, key_code 4'h0, both counters 0.
REQ-024 Reset SHALL take priority over all transitions; asserting it mid-DEBOUNCE, PRESENT or RELEASE SHALL discard the pending key with no transfer.
REQ-025 After reset deasserts, scanning SHALL restart at row 0 with a full SETTLE wait.

Verification
REQ-026 Idle, col = 4'hF, defaults: row SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110 with SETTLE+1 cycles per row, and key_valid SHALL stay 0.
REQ-027 Key at row 2, col 1 held, key_ready = 1: key_valid SHALL go high for one cycle with key_code = 4'h9, exactly DELAY+1 cycles after DEBOUNCE entry.
REQ-028 Bounce, where col toggles 1101/1111 every cycle on row 0: no key_valid SHALL be raised; after bouncing stops, stable 1101 SHALL yield key_code = 4'h1.
REQ-029 Backpressure, key_ready = 0 for 10 cycles after key_valid, key released meanwhile: key_valid and key_code SHALL hold; one transfer on key_ready = 1, then rows SHALL resume after DELAY+1 released cycles.
REQ-030 Multi-key col = 4'b0101 on row 3: key_code SHALL be 4'hD; the key held indefinitely SHALL produce no second transfer.
REQ-031 g_reset pulsed for one cycle during PRESENT: the next cycle SHALL show key_valid = 0, row = 4'b1110 and key_code = 4'h0.
